// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the stage sequencer and the five core stages.
// The sequencer takes the slave view; whoever drives start/halt/stage_done takes master.
interface stage_sequencer_if #(
   parameter int CNT_W = 32
);
   logic             start;
   logic             halt_req;
   logic             skip_mem;
   logic [4:0]       stage_done;
   logic [4:0]       stage_en;
   logic [2:0]       cur_stage;
   logic             busy;
   logic             halted;
   logic             error;
   logic [CNT_W-1:0] retired;

   modport master (
      output start, halt_req, skip_mem, stage_done,
      input  stage_en, cur_stage, busy, halted, error, retired
   );

   modport slave (
      input  start, halt_req, skip_mem, stage_done,
      output stage_en, cur_stage, busy, halted, error, retired
   );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle control FSM for the five-stage non-pipelined core: issues one
// enable pulse per stage, waits for its done level, retires, halts or times out.
module stage_sequencer #(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   stage_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_HALTED = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   localparam logic [2:0]  LP_STG_FETCH = 3'd0;
   localparam logic [2:0]  LP_STG_EXEC  = 3'd2;
   localparam logic [2:0]  LP_STG_WRITE = 3'd4;
   localparam logic [15:0] LP_WAIT_LAST = 16'(TIMEOUT - 1);

   state_t           r_state;
   logic [2:0]       r_stg;
   logic [15:0]      r_wcnt;
   logic [CNT_W-1:0] r_retired;

   state_t           w_state_nxt;
   logic [2:0]       w_stg_nxt;
   logic [15:0]      w_wcnt_nxt;
   logic             w_retire;
   logic             w_done;

   // State register: rst wins over everything, including a pending WAIT
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_stg     <= LP_STG_FETCH;
         r_wcnt    <= '0;
         r_retired <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_stg   <= w_stg_nxt;
         r_wcnt  <= w_wcnt_nxt;
         if (w_retire) begin
            r_retired <= r_retired + 1'b1;
         end
      end
   end

   // Next-state logic; done is only looked at in WAIT because stages hold
   // their completed level across instructions.
   always_comb begin
      w_state_nxt = r_state;
      w_stg_nxt   = r_stg;
      w_wcnt_nxt  = r_wcnt;
      w_retire    = 1'b0;
      w_done      = bus.stage_done[r_stg];

      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state_nxt = ST_ISSUE;
               w_stg_nxt   = LP_STG_FETCH;
            end
         end

         ST_ISSUE: begin
            w_state_nxt = ST_WAIT;
            w_wcnt_nxt  = '0;
         end

         ST_WAIT: begin
            if (w_done) begin
               if (r_stg == LP_STG_WRITE) begin
                  w_retire = 1'b1;
                  if (bus.halt_req) begin
                     w_state_nxt = ST_HALTED;
                  end else begin
                     w_state_nxt = ST_ISSUE;
                     w_stg_nxt   = LP_STG_FETCH;
                  end
               end else if ((r_stg == LP_STG_EXEC) && bus.skip_mem) begin
                  w_state_nxt = ST_ISSUE;
                  w_stg_nxt   = LP_STG_WRITE;
               end else begin
                  w_state_nxt = ST_ISSUE;
                  w_stg_nxt   = r_stg + 3'd1;
               end
            end else if (r_wcnt == LP_WAIT_LAST) begin
               // A done arriving on this same cycle is handled above and wins
               w_state_nxt = ST_ERROR;
            end else begin
               w_wcnt_nxt = r_wcnt + 16'd1;
            end
         end

         ST_HALTED: w_state_nxt = ST_HALTED;
         ST_ERROR:  w_state_nxt = ST_ERROR;

         default: begin
            w_state_nxt = ST_IDLE;
            w_stg_nxt   = LP_STG_FETCH;
         end
      endcase
   end

   // Outputs are decoded from registers only
   always_comb begin
      bus.stage_en  = 5'b00000;
      bus.busy      = 1'b0;
      bus.halted    = 1'b0;
      bus.error     = 1'b0;
      bus.cur_stage = r_stg;
      bus.retired   = r_retired;

      case (r_state)
         ST_ISSUE: begin
            bus.stage_en = 5'(5'b00001 << r_stg);
            bus.busy     = 1'b1;
         end
         ST_WAIT:   bus.busy   = 1'b1;
         ST_HALTED: bus.halted = 1'b1;
         ST_ERROR:  bus.error  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: table-driven instruction flow plus
// hand-written halt, timeout and mid-WAIT reset sequences.
module tb_stage_sequencer;

   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst;

   int n_cmp = 0;
   int n_bad = 0;

   stage_sequencer_if #(.CNT_W(32)) bus ();

   stage_sequencer #(.TIMEOUT(TO), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        halt;
      logic        skip;
      logic [4:0]  done;
      logic [4:0]  en;
      logic [2:0]  cur;
      logic        busy;
      logic        halted;
      logic        error;
      logic [31:0] ret;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic st, input logic hl, input logic sk,
                               input logic [4:0] dn, input logic [4:0] en,
                               input logic [2:0] cur, input logic by,
                               input logic ht, input logic er, input logic [31:0] rt);
      vec_t v;
      v.start = st; v.halt = hl; v.skip = sk; v.done = dn;
      v.en = en; v.cur = cur; v.busy = by; v.halted = ht; v.error = er; v.ret = rt;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic st, input logic hl, input logic sk, input logic [4:0] dn);
      bus.start = st; bus.halt_req = hl; bus.skip_mem = sk; bus.stage_done = dn;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 5'b00000);
      cyc();
      rst = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".en"},     64'(bus.stage_en),  64'h0);
      chk({tag, ".busy"},   64'(bus.busy),      64'h0);
      chk({tag, ".halted"}, 64'(bus.halted),    64'h0);
      chk({tag, ".error"},  64'(bus.error),     64'h0);
      chk({tag, ".cur"},    64'(bus.cur_stage), 64'h0);
      chk({tag, ".ret"},    64'(bus.retired),   64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      do_reset();
      chk_idle("reset");

      // start, halt, skip, done | en, cur, busy, halted, error, retired
      add(1,0,0,5'h00, 5'h00,0,0,0,0,0);
      add(0,0,0,5'h00, 5'h01,0,1,0,0,0);
      add(0,0,0,5'h01, 5'h00,0,1,0,0,0);
      add(0,0,0,5'h00, 5'h02,1,1,0,0,0);
      add(1,0,0,5'h02, 5'h00,1,1,0,0,0);
      add(0,0,0,5'h00, 5'h04,2,1,0,0,0);
      add(0,0,0,5'h04, 5'h00,2,1,0,0,0);
      add(0,0,0,5'h00, 5'h08,3,1,0,0,0);
      add(0,0,0,5'h08, 5'h00,3,1,0,0,0);
      add(0,0,0,5'h00, 5'h10,4,1,0,0,0);
      add(0,0,0,5'h10, 5'h00,4,1,0,0,0);
      add(0,0,0,5'h00, 5'h01,0,1,0,0,1);
      add(0,0,0,5'h01, 5'h00,0,1,0,0,1);
      add(0,0,0,5'h00, 5'h02,1,1,0,0,1);
      add(0,0,0,5'h02, 5'h00,1,1,0,0,1);
      add(0,0,0,5'h00, 5'h04,2,1,0,0,1);
      add(0,0,1,5'h04, 5'h00,2,1,0,0,1);
      add(0,0,0,5'h00, 5'h10,4,1,0,0,1);
      add(0,0,0,5'h10, 5'h00,4,1,0,0,1);
      add(0,0,0,5'h1f, 5'h01,0,1,0,0,2);
      add(0,0,0,5'h1f, 5'h00,0,1,0,0,2);
      add(0,0,0,5'h1f, 5'h02,1,1,0,0,2);
      add(0,0,0,5'h1f, 5'h00,1,1,0,0,2);
      add(0,0,0,5'h1f, 5'h04,2,1,0,0,2);
      add(0,0,0,5'h1f, 5'h00,2,1,0,0,2);
      add(0,0,0,5'h1f, 5'h08,3,1,0,0,2);
      add(0,0,0,5'h1f, 5'h00,3,1,0,0,2);
      add(0,0,0,5'h1f, 5'h10,4,1,0,0,2);
      add(0,1,0,5'h1f, 5'h00,4,1,0,0,2);
      add(0,0,0,5'h00, 5'h00,4,0,1,0,3);

      foreach (vecs[i]) begin
         chk($sformatf("vec%0d.en", i),     64'(bus.stage_en),  64'(vecs[i].en));
         chk($sformatf("vec%0d.cur", i),    64'(bus.cur_stage), 64'(vecs[i].cur));
         chk($sformatf("vec%0d.busy", i),   64'(bus.busy),      64'(vecs[i].busy));
         chk($sformatf("vec%0d.halted", i), 64'(bus.halted),    64'(vecs[i].halted));
         chk($sformatf("vec%0d.error", i),  64'(bus.error),     64'(vecs[i].error));
         chk($sformatf("vec%0d.ret", i),    64'(bus.retired),   64'(vecs[i].ret));
         drive(vecs[i].start, vecs[i].halt, vecs[i].skip, vecs[i].done);
         cyc();
      end

      // HALTED is sticky and ignores start
      for (int i = 0; i < 100; i++) begin
         drive((i == 10) || (i == 11), 1'b0, 1'b0, 5'h1f);
         chk($sformatf("halt%0d.en", i),     64'(bus.stage_en), 64'h0);
         chk($sformatf("halt%0d.busy", i),   64'(bus.busy),     64'h0);
         chk($sformatf("halt%0d.halted", i), 64'(bus.halted),   64'h1);
         chk($sformatf("halt%0d.ret", i),    64'(bus.retired),  64'h3);
         cyc();
      end

      // Decode never completes: error 9 cycles after decode ISSUE
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 5'h00); cyc();
      drive(1'b0, 1'b0, 1'b0, 5'h00); cyc();
      drive(1'b0, 1'b0, 1'b0, 5'h01); cyc();
      chk("to.issue_en", 64'(bus.stage_en), 64'h02);
      drive(1'b0, 1'b0, 1'b0, 5'h00);
      for (int k = 1; k <= TO; k++) begin
         cyc();
         chk($sformatf("to.wait%0d.error", k), 64'(bus.error), 64'h0);
         chk($sformatf("to.wait%0d.busy", k),  64'(bus.busy),  64'h1);
      end
      cyc();
      chk("to.error", 64'(bus.error),     64'h1);
      chk("to.cur",   64'(bus.cur_stage), 64'h1);
      chk("to.busy",  64'(bus.busy),      64'h0);
      chk("to.en",    64'(bus.stage_en),  64'h0);
      drive(1'b1, 1'b0, 1'b0, 5'h1f);
      for (int k = 0; k < 5; k++) cyc();
      chk("to.sticky", 64'(bus.error),    64'h1);
      chk("to.stk_en", 64'(bus.stage_en), 64'h0);

      // Done on the last allowed WAIT cycle advances without error
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 5'h00); cyc();
      drive(1'b0, 1'b0, 1'b0, 5'h00); cyc();
      drive(1'b0, 1'b0, 1'b0, 5'h01); cyc();
      drive(1'b0, 1'b0, 1'b0, 5'h00);
      for (int k = 1; k <= TO; k++) begin
         cyc();
         if (k == TO) drive(1'b0, 1'b0, 1'b0, 5'h02);
      end
      cyc();
      chk("late.en",    64'(bus.stage_en),  64'h04);
      chk("late.cur",   64'(bus.cur_stage), 64'h2);
      chk("late.error", 64'(bus.error),     64'h0);

      // Reset in the middle of exec WAIT with five instructions retired
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 5'h1f); cyc();
      drive(1'b0, 1'b0, 1'b0, 5'h1f);
      for (int k = 0; k < 55; k++) cyc();
      chk("mid.cur",  64'(bus.cur_stage), 64'h2);
      chk("mid.busy", 64'(bus.busy),      64'h1);
      chk("mid.en",   64'(bus.stage_en),  64'h0);
      chk("mid.ret",  64'(bus.retired),   64'h5);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 5'h00);
      cyc();
      rst = 1'b0;
      chk_idle("mid.rst");
      cyc();
      chk("mid.idle_busy", 64'(bus.busy), 64'h0);
      drive(1'b1, 1'b0, 1'b0, 5'h00); cyc();
      drive(1'b0, 1'b0, 1'b0, 5'h00);
      chk("mid.restart_en",  64'(bus.stage_en),  64'h01);
      chk("mid.restart_cur", 64'(bus.cur_stage), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
